dff_bank_write_arbiter: RTL and testbench

//  Round-robin write arbiter in front of a bank of N_REG 8-bit D-FF registers.

---
 rtl/dff_bank_pkg.sv | 20 ++
 rtl/reg8_slice.sv | 38 +++
 rtl/dff_bank_write_arbiter.sv | 134 +++++++++++++
 tb/tb_dff_bank_write_arbiter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/dff_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dff_bank_pkg
// Brief    : Shared word type, data width and round-robin pointer helper for
//            the register-bank write arbiter.
// Revision : 1.0  initial release
// ============================================================================
package dff_bank_pkg;

    localparam int DW = 8;

    typedef logic [7:0] reg8_t;

    // Advance a round-robin pointer by one, wrapping at n.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg8_slice.sv
`default_nettype none
// ============================================================================
// Module   : reg8_slice
// Brief    : One 8-bit bank register with synchronous reset and write enable.
// Revision : 1.0  initial release
// ============================================================================
module reg8_slice
    import dff_bank_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  i_we,
    input  reg8_t i_d,
    output reg8_t o_q
);

    reg8_t r_data_q;
    reg8_t w_data_d;

    always_comb begin
        w_data_d = r_data_q;
        if (i_we) begin
            w_data_d = i_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_q <= '0;
        end else begin
            r_data_q <= w_data_d;
        end
    end

    assign o_q = r_data_q;

endmodule
`default_nettype wire

// File: rtl/dff_bank_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dff_bank_write_arbiter
// Brief    : Round-robin arbiter sharing one write port of an 8-bit register
//            bank among N_REQ requesters; registered read port, commit counter.
// Revision : 1.0  initial release
// ============================================================================
module dff_bank_write_arbiter
    import dff_bank_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int N_REG = 8,
    parameter int AW    = $clog2(N_REG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*AW-1:0] req_addr,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]    gnt,
    input  logic                freeze,
    input  logic [AW-1:0]       rd_addr,
    output logic [DW-1:0]       rd_data,
    output logic [15:0]         commit_cnt
);

    localparam int c_ptr_w = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [c_ptr_w-1:0] r_rr_ptr_q;
    logic [c_ptr_w-1:0] w_rr_ptr_d;
    logic [15:0]        r_cnt_q;
    logic [15:0]        w_cnt_d;
    reg8_t              r_rd_data_q;
    reg8_t              w_rd_data_d;

    logic [c_ptr_w-1:0] w_idx [N_REQ];
    logic [c_ptr_w-1:0] w_win;
    logic               w_any;
    logic [N_REQ-1:0]   w_gnt;
    logic [AW-1:0]      w_wr_addr;
    reg8_t              w_wr_data;
    logic [N_REG-1:0]   w_we;
    reg8_t              w_bank [N_REG];

    // Search order: w_idx[k] is the requester examined k places after the pointer.
    always_comb begin
        w_idx[0] = r_rr_ptr_q;
        for (int k = 1; k < N_REQ; k++) begin
            w_idx[k] = c_ptr_w'(rr_next(32'(w_idx[k-1]), N_REQ));
        end
    end

    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        if (!rst && !freeze) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (!w_any && req[w_idx[k]]) begin
                    w_any = 1'b1;
                    w_win = w_idx[k];
                end
            end
        end
        w_gnt = w_any ? (N_REQ'(1) << w_win) : '0;
    end

    always_comb begin
        w_wr_addr = '0;
        w_wr_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt[i]) begin
                w_wr_addr = req_addr[i*AW +: AW];
                w_wr_data = req_data[i*DW +: DW];
            end
        end
    end

    // Out-of-range addresses match no slice, so the bank is left untouched.
    always_comb begin
        w_we = '0;
        for (int i = 0; i < N_REG; i++) begin
            w_we[i] = w_any && (w_wr_addr == AW'(i));
        end
    end

    generate
        for (genvar gi = 0; gi < N_REG; gi++) begin : g_slice
            reg8_slice u_slice (
                .clk  (clk),
                .rst  (rst),
                .i_we (w_we[gi]),
                .i_d  (w_wr_data),
                .o_q  (w_bank[gi])
            );
        end
    endgenerate

    // Reads sample the bank before this edge's write, returning the old value.
    always_comb begin
        w_rd_data_d = '0;
        for (int i = 0; i < N_REG; i++) begin
            if (rd_addr == AW'(i)) begin
                w_rd_data_d = w_bank[i];
            end
        end
    end

    always_comb begin
        w_rr_ptr_d = r_rr_ptr_q;
        w_cnt_d    = r_cnt_q;
        if (w_any) begin
            w_rr_ptr_d = c_ptr_w'(rr_next(32'(w_win), N_REQ));
            w_cnt_d    = r_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr_q  <= '0;
            r_cnt_q     <= '0;
            r_rd_data_q <= '0;
        end else begin
            r_rr_ptr_q  <= w_rr_ptr_d;
            r_cnt_q     <= w_cnt_d;
            r_rd_data_q <= w_rd_data_d;
        end
    end

    assign gnt        = w_gnt;
    assign rd_data    = r_rd_data_q;
    assign commit_cnt = r_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_dff_bank_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dff_bank_write_arbiter
// Brief    : Directed bench for the bank write arbiter (N_REQ=4, N_REG=6).
// Revision : 1.0  initial release
// ============================================================================
module tb_dff_bank_write_arbiter;

    localparam int c_nreq = 4;
    localparam int c_nreg = 6;
    localparam int c_aw   = 3;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [c_nreq-1:0]      req;
    logic [c_nreq*c_aw-1:0] req_addr;
    logic [c_nreq*8-1:0]    req_data;
    logic [c_nreq-1:0]      gnt;
    logic                   freeze;
    logic [c_aw-1:0]        rd_addr;
    logic [7:0]             rd_data;
    logic [15:0]            commit_cnt;

    int checks = 0;
    int errors = 0;

    logic [7:0]  m_bank [c_nreg];
    int          m_ptr;
    logic [15:0] m_cnt;
    logic [7:0]  rd_q [$];

    dff_bank_write_arbiter #(.N_REQ(c_nreq), .N_REG(c_nreg)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .gnt        (gnt),
        .freeze     (freeze),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .commit_cnt (commit_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [2:0] a, input logic [7:0] d);
        req[i]             = 1'b1;
        req_addr[i*3 +: 3] = a;
        req_data[i*8 +: 8] = d;
    endtask

    // One clock: inputs already driven after a falling edge.
    task automatic step(input string tag);
        int         win;
        int         j;
        logic [3:0] exp_gnt;
        logic [2:0] a;
        logic [7:0] rd_exp;
        #1;
        win = -1;
        if (!rst && !freeze) begin
            for (int k = 0; k < c_nreq; k++) begin
                j = (m_ptr + k) % c_nreq;
                if (win < 0 && req[j]) win = j;
            end
        end
        exp_gnt = (win < 0) ? 4'b0000 : 4'(1 << win);
        check({tag, ".gnt"}, 16'(gnt), 16'(exp_gnt));
        if (rst) rd_q.push_back(8'h00);
        else if (int'(rd_addr) < c_nreg) rd_q.push_back(m_bank[rd_addr]);
        else rd_q.push_back(8'h00);
        if (rst) begin
            for (int i = 0; i < c_nreg; i++) m_bank[i] = 8'h00;
            m_ptr = 0;
            m_cnt = 16'd0;
        end else if (win >= 0) begin
            a = req_addr[win*3 +: 3];
            if (int'(a) < c_nreg) m_bank[a] = req_data[win*8 +: 8];
            m_ptr = (win + 1) % c_nreq;
            m_cnt = m_cnt + 16'd1;
        end
        @(posedge clk);
        #1;
        rd_exp = rd_q.pop_front();
        check({tag, ".rd"}, 16'(rd_data), 16'(rd_exp));
        check({tag, ".cnt"}, commit_cnt, m_cnt);
        @(negedge clk);
    endtask

    initial begin
        rst      = 1'b1;
        req      = '0;
        req_addr = '0;
        req_data = '0;
        freeze   = 1'b0;
        rd_addr  = '0;
        m_ptr    = 0;
        m_cnt    = 16'd0;
        for (int i = 0; i < c_nreg; i++) m_bank[i] = 8'h00;
        @(negedge clk);

        // Reset for two cycles, then sweep every read address.
        step("rst0");
        step("rst1");
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            step("rdsweep");
        end

        // Single request from requester 2.
        set_req(2, 3'd5, 8'hA5);
        rd_addr = 3'd5;
        step("single");
        req = '0;
        step("single_rd");
        check("single_val", 16'(rd_data), 16'h00A5);

        // Pointer sits at 3 after the single grant; then a full rotation twice.
        for (int i = 0; i < c_nreq; i++) set_req(i, 3'(i + 2), 8'(8'h10 + i));
        step("ptr3");
        for (int n = 0; n < 8; n++) begin
            rd_addr = 3'(2 + (n % 4));
            step("rr");
        end
        check("rr_cnt", commit_cnt, 16'd10);

        // Freeze blocks grants; release grants requester 0.
        req    = 4'b0011;
        freeze = 1'b1;
        step("frz0");
        step("frz1");
        freeze = 1'b0;
        step("unfrz");
        req = '0;

        // Same-cycle write and read of address 1.
        set_req(1, 3'd1, 8'h3C);
        rd_addr = 3'd1;
        step("wr_rd_same");
        req = '0;
        step("wr_rd_next");

        // Out-of-range address: granted, bank unchanged.
        set_req(3, 3'd7, 8'hFF);
        step("oor");
        req = '0;
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            step("oor_sweep");
        end

        // Reset arriving with a valid grant discards the write.
        set_req(0, 3'd0, 8'h77);
        rst = 1'b1;
        step("rst_mid");
        rst = 1'b0;
        req = '0;
        for (int i = 0; i < c_nreg; i++) begin
            rd_addr = 3'(i);
            step("post_rst");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
